// File: rtl/mem_pkg.sv
// Shared definitions for the mem_bank block.
// Holds the FSM state enumeration and the default word/address widths.
package mem_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned DEFAULT_ADDR_W = 3;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_bank_if.sv
// Request/response bus of mem_bank.
// master: issues requests, consumes responses (testbench / client side)
// slave : accepts requests, produces read responses (mem_bank side)
// Signals: req_valid/req_ready/req_we/req_addr/req_wdata, rsp_valid/rsp_ready/rsp_rdata
interface mem_bank_if
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_bank_array.sv
// Word storage for mem_bank: one write port, one synchronous read port, no reset.
// Ports: clk; we/waddr/wdata (write); re/raddr (read enable/address); rdata (registered read data,
// updated only when re is high so it holds between reads).
module mem_bank_array #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is zeroed by the controller's clear sweep, never by reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/mem_bank.sv
// Single-port memory bank with valid/ready request and response channels and a
// clear sweep that zeroes every word after reset and on clr_req.
// Ports: clk, rst_n (async active-low); bus (mem_bank_if.slave request/response);
// clr_req (zero whole array); init_done (sticky: array cleared since reset).
module mem_bank
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_bank_if.slave  bus,
    input  logic       clr_req,
    output logic       init_done
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              rsp_valid_q;
    logic              rd_seen;      // read register holds real data (not reset-able itself)

    logic              slot_free_c;  // IDLE, or RESP whose response is taken this edge
    logic              ready_c;
    logic              accept_c;
    logic              clr_go_c;
    logic              arr_we_c;
    logic [ADDR_W-1:0] arr_waddr_c;
    logic [DATA_W-1:0] arr_wdata_c;
    logic              arr_re_c;
    logic [DATA_W-1:0] arr_rdata;

    // Handshake decode from registered state plus the qualifying inputs
    always_comb begin
        slot_free_c = (state == IDLE) || ((state == RESP) && bus.rsp_ready);
        ready_c     = slot_free_c && !clr_req;
        accept_c    = bus.req_valid && ready_c;
        clr_go_c    = slot_free_c && clr_req;
    end

    // Array port steering: the sweep owns the write port while clearing
    always_comb begin
        arr_we_c    = 1'b0;
        arr_waddr_c = bus.req_addr;
        arr_wdata_c = bus.req_wdata;
        arr_re_c    = accept_c && !bus.req_we;
        if (state == CLEAR) begin
            arr_we_c    = 1'b1;
            arr_waddr_c = clr_cnt;
            arr_wdata_c = '0;
        end else if (accept_c && bus.req_we) begin
            arr_we_c = 1'b1;
        end
    end

    // Control FSM, clear counter and response flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CLEAR;
            clr_cnt     <= '0;
            rsp_valid_q <= 1'b0;
            rd_seen     <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end
                end
                IDLE, RESP: begin
                    if (clr_go_c) begin
                        state       <= CLEAR;
                        clr_cnt     <= '0;
                        rsp_valid_q <= 1'b0;
                    end else if (accept_c && !bus.req_we) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rd_seen     <= 1'b1;
                    end else if (slot_free_c) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    clr_cnt <= '0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    // Read register has no reset, so present zero until the first read loads it
    assign bus.rsp_rdata = rd_seen ? arr_rdata : '0;

    mem_bank_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we_c),
        .waddr (arr_waddr_c),
        .wdata (arr_wdata_c),
        .re    (arr_re_c),
        .raddr (bus.req_addr),
        .rdata (arr_rdata)
    );
endmodule

// File: tb/tb_mem_bank.sv
// Directed self-checking bench for mem_bank (DATA_W=8, ADDR_W=3).
module tb_mem_bank;
    logic clk;
    logic rst_n;
    logic clr_req;
    logic init_done;

    int n_asserts = 0;
    int n_fail    = 0;

    mem_bank_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    mem_bank #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clr_req   (clr_req),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        tick();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [2:0] a, input logic [7:0] exp);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = a;
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.rsp_rdata), 32'(exp));
        tick();
    endtask

    task automatic check_sweep(input string tag, input logic exp_done_early);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
            chk({tag, "_rvalid"}, 32'(bus.rsp_valid), 32'd0);
            chk({tag, "_done_pre"}, 32'(init_done), 32'(exp_done_early));
            tick();
        end
        chk({tag, "_done"}, 32'(init_done), 32'd1);
        chk({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        clr_req       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);

        // Post-reset sweep: init_done rises on the 8th edge after release
        rst_n = 1'b1;
        check_sweep("sweep0", 1'b0);

        for (int i = 0; i < 8; i++) do_read("zero_rd", 3'(i), 8'h00);

        // Write then read the same word on the very next cycle
        do_write(3'd3, 8'hA5);
        do_read("rd_after_wr", 3'd3, 8'hA5);

        // Stalled response: held stable, requests ignored
        do_write(3'd5, 8'h5C);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 3'd5;
        bus.rsp_ready = 1'b0;
        tick();
        bus.req_we    = 1'b1;
        bus.req_wdata = 8'h11;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_data", 32'(bus.rsp_rdata), 32'h5C);
            chk("stall_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        chk("stall_release_ready", 32'(bus.req_ready), 32'd1);
        tick();
        chk("stall_done_valid", 32'(bus.rsp_valid), 32'd0);
        do_read("stall_wr_ignored", 3'd5, 8'h5C);

        // Streamed reads, one response per cycle
        for (int i = 0; i < 8; i++) do_write(3'(i), 8'(8'h10 + i));
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            bus.req_addr  = 3'(i);
            #1;
            chk("stream_ready", 32'(bus.req_ready), 32'd1);
            tick();
            chk("stream_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stream_data", 32'(bus.rsp_rdata), 32'(8'h10 + i));
        end
        bus.req_valid = 1'b0;
        tick();
        chk("stream_end_valid", 32'(bus.rsp_valid), 32'd0);

        // Fill with 0xFF, then clear on request
        for (int i = 0; i < 8; i++) do_write(3'(i), 8'hFF);
        do_read("fill_ff", 3'd6, 8'hFF);
        clr_req = 1'b1;
        #1;
        chk("clr_blocks_ready", 32'(bus.req_ready), 32'd0);
        tick();
        clr_req = 1'b0;
        check_sweep("sweep_clr", 1'b1);
        do_read("clr_rd0", 3'd0, 8'h00);
        do_read("clr_rd4", 3'd4, 8'h00);
        do_read("clr_rd7", 3'd7, 8'h00);

        // Reset in the middle of a sweep
        do_write(3'd2, 8'h77);
        do_read("pre_rst_rd", 3'd2, 8'h77);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_done", 32'(init_done), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_rdata", 32'(bus.rsp_rdata), 32'd0);
        tick();
        rst_n = 1'b1;
        check_sweep("sweep_rst", 1'b0);
        do_read("post_rst_rd2", 3'd2, 8'h00);
        do_read("post_rst_rd7", 3'd7, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
